// File: rtl/mem_pkg.sv
// Shared types and constants for the multicycle-MIPS memory responder.
package mem_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned MEM_DATA_W = 32;

    // wr encoding shared with the control unit
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RESP      = 2'd2,
        WRITE     = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write port, combinational read port; contents survive reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_ridx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fixed-latency reads, single-cycle writes, Ready/Busy handshake.
// Optional misaligned-address trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W       = MEM_DATA_W,
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset_signal,
    input  logic              Req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic              Busy,
    output logic              AddrError
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned CNT_LOAD = (READ_LATENCY > 2) ? (READ_LATENCY - 2) : 0;

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_misalign;
    logic              w_rdata_load;
    logic              w_err_nxt;
    logic              w_we;
    logic [IDX_W-1:0]  w_addr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_array_rdata;

    // Upper address bits wrap modulo the array depth
    assign w_addr_idx = Address[2 +: IDX_W];
    assign w_accept   = (r_state == IDLE) && Req;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_unused_addr;
    assign w_misalign    = (Address[1:0] != 2'b00);
    assign w_unused_addr = ^Address[ADDR_W-1:IDX_W+2];
`else
    logic w_unused_addr;
    assign w_misalign    = 1'b0;
    assign w_unused_addr = ^{Address[ADDR_W-1:IDX_W+2], Address[1:0]};
`endif

    // A latency-1 read samples the array while still IDLE, before the index is latched
    assign w_rd_idx = (r_state == IDLE) ? w_addr_idx : r_idx;
    assign w_we     = (r_state == WRITE);

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem_array (
        .i_clk     (Clk),
        .i_we      (w_we),
        .i_widx    (r_idx),
        .i_wdata   (r_wdata),
        .i_ridx    (w_rd_idx),
        .o_rdata_c (w_array_rdata)
    );

    // Next-state, counter and RESP-entry controls
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rdata_load = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (Req) begin
                    if (w_misalign) begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                    end else if (wr == MEM_WRITE) begin
                        w_state_nxt = WRITE;
                    end else if (READ_LATENCY <= 1) begin
                        w_state_nxt  = RESP;
                        w_rdata_load = 1'b1;
                    end else begin
                        w_state_nxt = READ_WAIT;
                        w_cnt_nxt   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            READ_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = RESP;
                    w_rdata_load = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            WRITE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            ReadData  <= '0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
            AddrError <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= w_addr_idx;
                r_wdata <= WriteData;
            end
            if (w_rdata_load) begin
                ReadData <= w_array_rdata;
            end
            Ready     <= (w_state_nxt == RESP) || (w_state_nxt == WRITE);
            Busy      <= (w_state_nxt != IDLE);
            AddrError <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: three instances (read latency 1, 2, 4) share stimulus
// and are checked cycle by cycle against a word-array reference model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int unsigned NDUT  = 3;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned KMAX  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd   [NDUT];
    logic        rdy  [NDUT];
    logic        busy [NDUT];
    logic        aerr [NDUT];

    logic [31:0] mem_model [DEPTH];
    logic [31:0] exp_rd;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_lat1 (
        .Clk(clk), .Reset_signal(rst_n), .Req(req), .wr(wr), .Address(addr),
        .WriteData(wdata), .ReadData(rd[0]), .Ready(rdy[0]), .Busy(busy[0]),
        .AddrError(aerr[0]));

    mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) u_lat2 (
        .Clk(clk), .Reset_signal(rst_n), .Req(req), .wr(wr), .Address(addr),
        .WriteData(wdata), .ReadData(rd[1]), .Ready(rdy[1]), .Busy(busy[1]),
        .AddrError(aerr[1]));

    mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(4)) u_lat4 (
        .Clk(clk), .Reset_signal(rst_n), .Req(req), .wr(wr), .Address(addr),
        .WriteData(wdata), .ReadData(rd[2]), .Ready(rdy[2]), .Busy(busy[2]),
        .AddrError(aerr[2]));

    function automatic int unsigned lat_of(input int unsigned d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One request; called and returns at a falling edge. Ready lands in cycle k == latency.
    task automatic xact(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                        input logic extra);
        int unsigned idx;
        int unsigned lat;
        logic        trap;
        idx  = (a / 4) % DEPTH;
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (a % 4) != 0;
`endif
        req = 1'b1; wr = is_wr; addr = a; wdata = d;
        for (int k = 1; k <= int'(KMAX); k++) begin
            @(negedge clk);
            for (int i = 0; i < int'(NDUT); i++) begin
                lat = (trap || is_wr) ? 1 : lat_of(i);
                chk($sformatf("L%0d k%0d ready", lat_of(i), k), 32'(rdy[i]), 32'(k == lat));
                chk($sformatf("L%0d k%0d busy", lat_of(i), k), 32'(busy[i]), 32'(k <= lat));
                chk($sformatf("L%0d k%0d addrerr", lat_of(i), k), 32'(aerr[i]),
                    32'(trap && (k == lat)));
                chk($sformatf("L%0d k%0d rdata a=%h", lat_of(i), k, a), rd[i],
                    (!is_wr && !trap && k >= lat) ? mem_model[idx] : exp_rd);
            end
            // Requests and input changes while busy must be ignored
            if (k == 1) begin
                req = extra; wr = 1'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
        end
        if (!trap && is_wr)  mem_model[idx] = d;
        if (!trap && !is_wr) exp_rd = mem_model[idx];
    endtask

    task automatic chk_all_idle(input string tag);
        for (int i = 0; i < int'(NDUT); i++) begin
            chk($sformatf("%s L%0d ready", tag, lat_of(i)), 32'(rdy[i]), 32'd0);
            chk($sformatf("%s L%0d busy", tag, lat_of(i)), 32'(busy[i]), 32'd0);
            chk($sformatf("%s L%0d addrerr", tag, lat_of(i)), 32'(aerr[i]), 32'd0);
            chk($sformatf("%s L%0d rdata", tag, lat_of(i)), rd[i], exp_rd);
        end
    endtask

    // Issue a request then assert reset one cycle later, mid-transaction
    task automatic reset_mid(input logic is_wr, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; wr = is_wr; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        exp_rd = 32'd0;
        #1;
        chk_all_idle(is_wr ? "rst_mid_wr" : "rst_mid_rd");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_all_idle("post_rst");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned w;
        rst_n = 1'b0; req = 1'b0; wr = MEM_READ; addr = '0; wdata = '0;
        exp_rd = 32'd0;
        repeat (2) @(negedge clk);
        chk_all_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back; wrap of address bits above the index
        xact(MEM_WRITE, 32'h10, 32'hDEAD_BEEF, 1'b0);
        xact(MEM_READ,  32'h10, 32'h0, 1'b0);
        xact(MEM_WRITE, 32'h400, 32'h11, 1'b0);
        xact(MEM_READ,  32'h0, 32'h0, 1'b1);

        // Fill every word so later reads have known contents
        for (int i = 0; i < int'(DEPTH); i++) begin
            xact(MEM_WRITE, 32'(i * 4), $urandom, 1'($urandom));
        end

        // Misaligned write, then read of the aligned word
        xact(MEM_WRITE, 32'h13, 32'h5, 1'b0);
        xact(MEM_READ,  32'h10, 32'h0, 1'b0);

        // Random mixed traffic across the full 32-bit address space
        for (int n = 0; n < 120; n++) begin
            xact(1'($urandom), $urandom, $urandom, 1'($urandom));
        end

        // Req held high: one acceptance per IDLE cycle, spacing latency + 1
        req = 1'b1; wr = MEM_READ; addr = 32'h20;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int i = 0; i < int'(NDUT); i++) begin
                w = lat_of(i);
                chk($sformatf("hold L%0d k%0d ready", w, k), 32'(rdy[i]),
                    32'((k % (w + 1)) == w));
                chk($sformatf("hold L%0d k%0d busy", w, k), 32'(busy[i]),
                    32'((k % (w + 1)) != 0));
                if ((k % (w + 1)) == w)
                    chk($sformatf("hold L%0d k%0d rdata", w, k), rd[i], mem_model[8]);
            end
        end
        req = 1'b0;
        repeat (5) @(negedge clk);
        exp_rd = mem_model[8];
        chk_all_idle("hold_drain");

        // Reset mid-read and mid-write; array contents must survive, pending write dropped
        a = 32'h44;
        xact(MEM_READ, a, 32'h0, 1'b0);
        reset_mid(MEM_READ, a, 32'h0);
        reset_mid(MEM_WRITE, a, ~mem_model[17]);
        xact(MEM_READ, a, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            xact(1'($urandom), $urandom, $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle MIPS datapath. It accepts single-word read and write requests from the control unit's memory port (wr, IorD-selected address) and services them from an internal word array. Reads complete after a fixed, configurable latency, the delay the control FSM's fetch-delay states budget for. An explicit Ready/Busy handshake lets future control revisions wait on the memory instead of counting cycles.

Parameters:
DATA_W, 32, word width in bits
DEPTH_WORDS, 256, number of words in the array (power of two)
READ_LATENCY, 2, cycles from the accepting edge to the Ready cycle for reads (minimum 1)

Ports:
Clk  in  1  system clock, rising edge
Reset_signal  in  1  asynchronous, active-low reset
Req  in  1  request strobe, sampled only while idle
wr  in  1  1 = write, 0 = read (same encoding as the control unit)
Address  in  32  byte address; word index = Address[2 +: log2(DEPTH_WORDS)]
WriteData  in  DATA_W  write data, captured with the request
ReadData  out  DATA_W  read result, valid from the Ready cycle, held until the next read response
Ready  out  1  one-cycle completion pulse
Busy  out  1  high whenever the FSM is not IDLE
AddrError  out  1  misalignment flag; driven only when MEM_MISALIGN_TRAP_EN is defined, else tied 0

Behaviour:
- Reset (Reset_signal low, asynchronous): state IDLE; ReadData=0, Ready=0, Busy=0, AddrError=0; latency counter=0.
- Reset does not clear array contents. An abandoned request is dropped and any pending write is not committed.
- FSM states: IDLE, READ_WAIT, RESP, WRITE.
- IDLE:
  - Req=1 at a rising edge is accepted: Address, wr and WriteData are latched.
  - wr=1 -> WRITE.
  - wr=0 with READ_LATENCY=1 -> RESP.
  - wr=0 otherwise -> READ_WAIT, counter loaded with READ_LATENCY-2.
- READ_WAIT: counter decrements each cycle; at 0 the FSM moves to RESP. The read is therefore Ready exactly READ_LATENCY cycles after the accepting edge.
- RESP: ReadData is registered from the array at the entry edge; Ready=1 for this single cycle; next state IDLE.
- WRITE: Ready=1 for one cycle; the array word is written at the edge leaving WRITE; next state IDLE. Write latency is fixed at 1.
- Busy=1 in READ_WAIT, RESP and WRITE.
- Req while Busy is ignored, not queued. The earliest next acceptance is the first IDLE edge, so the minimum back-to-back spacing is latency + 1 cycles.
- Latched request fields are stable for the whole transaction; input changes after acceptance have no effect.
- Address bits above the index wrap modulo DEPTH_WORDS. Bits [1:0] are ignored unless the trap feature is on.
- Read after write to the same word returns the new data.
- ReadData changes only on RESP entry; writes never alter ReadData.

Optional Feature:
Macro MEM_MISALIGN_TRAP_EN.
- Defined: an accepted request with Address[1:0]!=0 goes straight to RESP with AddrError=1 and Ready=1 for that cycle.
  - No array write occurs, and ReadData is held.
  - AddrError clears on the next cycle.
- Undefined: Address[1:0] is ignored and AddrError is tied 0.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, READ_WAIT, RESP, WRITE);
  - the MEM_READ=0 / MEM_WRITE=1 wr encoding constants;
  - the default DATA_W.
- Sub-module mem_array: DEPTH_WORDS x DATA_W storage with a synchronous write port (we, index, data) and a combinational read port. The FSM stays in mem_responder.

Test Plan:
1. Reset mid-read: accept a read at edge 0, pull Reset_signal low in READ_WAIT -> Busy=0, Ready=0, ReadData=0 immediately, and no Ready pulse follows.
2. Write then read: write 0xDEADBEEF to 0x10 -> Ready in the cycle after acceptance. Read 0x10 -> Ready exactly 2 cycles after acceptance, with ReadData=0xDEADBEEF.
3. Busy ignore: hold Req=1 continuously during a read of 0x20 -> exactly one transaction per IDLE entry, and the second is accepted only after Busy falls.
4. Wrap: with DEPTH_WORDS=256, write 0x11 to 0x400, then read 0x0 -> ReadData=0x11.
5. Latency sweep: READ_LATENCY=1 and 4 -> Ready at 1 and 4 cycles after acceptance respectively, and Ready is one cycle wide.
6. With MEM_MISALIGN_TRAP_EN, write 0x5 to 0x13 -> AddrError=1 and Ready=1 in the same cycle. A later read of 0x10 returns the prior contents, not 0x5.
